// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
//  Module   : wb_commit
//  Purpose  : Writeback commit unit. Queues ALU and load results in order and
//             drives one register-file write per cycle plus a pending-write
//             mask for decode hazard checks.
//             Optional macro WB_LOAD_EXT_EN: extract/extend load data before
//             enqueue (LB/LH/LBU/LHU).
//  Revision : 1.0 - initial release
// ============================================================================
module wb_commit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_data,
  output logic        WrEn,
  output logic [4:0]  rd,
  output logic [31:0] DIn,
  output logic [31:0] pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [36:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_wren;
  logic [4:0]    r_rd;
  logic [31:0]   r_din;

  logic [CW-1:0] w_free;
  logic [CW-1:0] w_npush;
  logic [PW-1:0] w_alu_wptr;
  logic          w_ld_push;
  logic          w_alu_push;
  logic          w_pop;
  logic [31:0]   w_ld_word;
  logic [31:0]   w_pend;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = ld_data[{ld_addr_lo, 3'b000} +: 8];
  assign w_half = ld_data[{ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_f3)
      3'b000:  w_ld_word = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_word = {24'd0, w_byte};
      3'b001:  w_ld_word = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_word = {16'd0, w_half};
      default: w_ld_word = ld_data;
    endcase
  end
`else
  logic w_unused_ld_sel;

  assign w_ld_word       = ld_data;
  assign w_unused_ld_sel = ^{ld_f3, ld_addr_lo};
`endif

  // Credit is based on the registered count only; a same-cycle pop does not free a slot.
  assign w_free    = CW'(DEPTH) - r_count;
  assign ld_ready  = !rst && (w_free >= CW'(1));
  assign alu_ready = !rst && ((w_free >= CW'(2)) || ((w_free >= CW'(1)) && !ld_valid));

  // x0 writes complete the handshake but never occupy a slot.
  assign w_ld_push  = ld_valid && ld_ready && (ld_rd != 5'd0);
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign w_npush    = CW'(w_ld_push) + CW'(w_alu_push);
  assign w_alu_wptr = r_wptr + PW'(w_ld_push);
  assign w_pop      = (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_ld_push) begin
      r_mem[r_wptr] <= {ld_rd, w_ld_word};
    end
    if (w_alu_push) begin
      r_mem[w_alu_wptr] <= {alu_rd, alu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wren  <= 1'b0;
      r_rd    <= 5'd0;
      r_din   <= 32'd0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_npush);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count + w_npush - CW'(w_pop);
      if (w_pop) begin
        r_wren        <= 1'b1;
        {r_rd, r_din} <= r_mem[r_rptr];
      end else begin
        r_wren <= 1'b0;
      end
    end
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    w_pend = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - r_rptr} < r_count) begin
        w_pend[r_mem[i][36:32]] = 1'b1;
      end
    end
    if (r_wren) begin
      w_pend[r_rd] = 1'b1;
    end
    w_pend[0] = 1'b0;
  end

  assign WrEn      = r_wren;
  assign rd        = r_rd;
  assign DIn       = r_din;
  assign pend_mask = w_pend;

endmodule
`default_nettype wire

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit for the RISC-V pipeline. It is the writer side of the register-file write port that the decode stage reads through. It accepts results from the ALU path and from the load path through valid/ready handshakes, and queues them in order in a small FIFO. It drives exactly one register-file write per cycle on `WrEn`/`rd`/`DIn`, and exports a pending-write mask that decode uses for hazard stalls.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result is offered this cycle.
- `alu_ready`  out  1  ALU result is accepted at this edge if `alu_valid` is high.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ld_valid`  in  1  load response is offered this cycle.
- `ld_ready`  out  1  load response is accepted at this edge if `ld_valid` is high.
- `ld_rd`  in  5  load destination register.
- `ld_f3`  in  3  load funct3 (LB/LH/LW/LBU/LHU).
- `ld_addr_lo`  in  2  byte offset of the load address.
- `ld_data`  in  32  raw aligned memory word.
- `WrEn`  out  1  register-file write enable.
- `rd`  out  5  register-file write address.
- `DIn`  out  32  register-file write data.
- `pend_mask`  out  32  bit i set means a write to x_i is queued or currently presented.

## Operation
- The FIFO holds `{rd, data}` entries. `count` ranges 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- Free slots: `free = DEPTH - count`, computed from the registered `count`. A slot vacated by a pop in the same cycle is not credited.
- `ld_ready = !rst && free >= 1`.
- `alu_ready = !rst && (free >= 2 || (free >= 1 && !ld_valid))`. The load path has priority.
- When both are accepted in one edge, the load entry is enqueued first and the ALU entry second. Program order is load older.
- A handshake with destination 0 (`*_rd == 0`) completes normally but stores nothing. It does not consume a slot and does not affect `pend_mask`.
- Pop: at each edge with `count > 0`, the head entry moves into the output registers and `WrEn` is set to 1. At an edge with `count == 0`, `WrEn` is set to 0; `rd` and `DIn` hold their values.
- Push and pop in the same edge are both performed: `count` changes by pushes minus pops.
- `pend_mask` is combinational: the OR of one-hot(rd) over all valid FIFO entries, plus the output `rd` when `WrEn` is 1. Bit 0 is always 0.
- There is no internal state machine beyond the FIFO pointers and `count`. No stall of the output side exists, because the register file always accepts a write.

## Timing
- Reset values: `WrEn`=0, `rd`=0, `DIn`=0, `count`=0, both pointers 0, `pend_mask`=0. Both readies are 0 while `rst` is high and 1 in the first cycle after it deasserts.
- Reset mid-operation discards every queued entry and the presented write. No write occurs in the cycle after the reset edge.
- Latency with an empty FIFO: an entry accepted at edge E is enqueued at E and popped to the outputs at E+1. `WrEn` is high in the cycle after E+1, and the register file commits at E+2.
- Throughput is one commit per cycle. Two accepts in one cycle drain over two cycles.
- Full (`count == DEPTH`): both readies are 0. At `count == DEPTH-1` with both valid, only the load is accepted.

## Configuration
- `WB_LOAD_EXT_EN` defined: load data is extracted and extended before enqueue.
  - `ld_f3` 000 (LB): byte `ld_data[8*ld_addr_lo +: 8]`, sign-extended.
  - 100 (LBU): the same byte, zero-extended.
  - 001 (LH): halfword `ld_data[16*ld_addr_lo[1] +: 16]`, sign-extended.
  - 101 (LHU): the same halfword, zero-extended.
  - 010 (LW) and all other codes: `ld_data` unchanged.
- `WB_LOAD_EXT_EN` not defined: `ld_data` is enqueued unchanged, and `ld_f3`/`ld_addr_lo` are ignored. The memory stage must then deliver final values.

## Test plan
- Reset, then a single ALU accept with rd=5, data=0x00000042. Required: `WrEn`=1, `rd`=5, `DIn`=0x42 exactly two edges after the accept, for one cycle. `pend_mask`=0x20 from the accept until `WrEn` falls.
- Load and ALU valid in the same cycle (ld rd=3, data=0x11; alu rd=4, data=0x22), FIFO empty. Required: both accepted; writes appear on consecutive cycles, rd=3 first, then rd=4.
- Fill to DEPTH=4 with ALU writes while `WrEn` continues draining. Required: `alu_ready`=0 at count 4. At count 3 with both valid, `ld_ready`=1 and `alu_ready`=0.
- ALU accept with rd=0, data=0xFFFFFFFF. Required: no `WrEn` pulse, `count` unchanged, `pend_mask`=0.
- With `WB_LOAD_EXT_EN` defined: `ld_data`=0x80FF7F01.
  - LB at offset 1 → `DIn`=0x0000007F.
  - LB at offset 3 → 0xFFFFFF80.
  - LHU at offset 2 → 0x000080FF.
  - LH at offset 2 → 0xFFFF80FF.
- Assert `rst` with 3 queued entries. Required: no `WrEn` after the reset edge, `pend_mask`=0, both readies return to 1 the cycle after `rst` falls.
